fifo_s2b_sync: RTL and testbench

//   Single-clock narrow-to-wide packing FIFO; parametrised successor to the 4-bit->16-bit small2big FIFO.

---
 rtl/fifo_s2b_sync_pkg.sv | 14 +
 rtl/fifo_pack_lane.sv | 65 ++++++
 rtl/fifo_s2b_sync.sv | 111 +++++++++++
 tb/tb_fifo_s2b_sync.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_s2b_sync_pkg.sv
// Shared defaults and lane-placement helper for the narrow-to-wide packing FIFO.
package fifo_s2b_sync_pkg;

    localparam int DEF_DIN_W = 4;
    localparam int DEF_RATIO = 4;
    localparam int DEF_DEPTH = 8;

    // Bit offset of packer lane `lane` inside the wide word.
    function automatic int lane_lsb(input int lane, input int din_w, input int ratio,
                                    input bit msb_first);
        return msb_first ? (ratio - 1 - lane) * din_w : lane * din_w;
    endfunction

endpackage

// File: rtl/fifo_pack_lane.sv
// Packer: collects RATIO narrow words, pads on flush, and strobes one push per wide word.
module fifo_pack_lane
    import fifo_s2b_sync_pkg::*;
#(
    parameter int              DIN_W     = DEF_DIN_W,
    parameter int              RATIO     = DEF_RATIO,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [DIN_W-1:0] PAD_VAL  = '0,
    parameter int              DOUT_W    = DIN_W * RATIO,
    parameter int              LANE_W    = $clog2(RATIO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_acc,
    input  logic              flush,
    input  logic              full,
    output logic [DOUT_W-1:0] word,
    output logic              push,
    output logic [LANE_W-1:0] lane_cnt
);

    logic [DIN_W-1:0] lane_q [RATIO];
    logic             last_lane;
    logic             has_data;
    logic             flush_go;
    logic [DIN_W-1:0] lane_val;

    always_comb begin
        last_lane = (lane_cnt == LANE_W'(RATIO - 1));
        has_data  = (lane_cnt != '0) || din_acc;
        // Padding push is held off while full; the level flush simply retries.
        flush_go  = flush && has_data && !full;
        push      = (din_acc && last_lane) || flush_go;
    end

    always_comb begin
        word     = '0;
        lane_val = PAD_VAL;
        for (int i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) < lane_cnt)
                lane_val = lane_q[i];
            else if ((LANE_W'(i) == lane_cnt) && din_acc)
                lane_val = din;
            else
                lane_val = PAD_VAL;
            word[lane_lsb(i, DIN_W, RATIO, MSB_FIRST) +: DIN_W] = lane_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            lane_cnt <= '0;
        else if (push)
            lane_cnt <= '0;
        else if (din_acc)
            lane_cnt <= lane_cnt + LANE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (din_acc)
            lane_q[lane_cnt] <= din;
    end

endmodule

// File: rtl/fifo_s2b_sync.sv
// Single-clock narrow-to-wide packing FIFO: packer front end, DEPTH-entry FWFT store, registered flags.
module fifo_s2b_sync
    import fifo_s2b_sync_pkg::*;
#(
    parameter int               DIN_W      = DEF_DIN_W,
    parameter int               RATIO      = DEF_RATIO,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter int               PROG_FULL  = 6,
    parameter int               PROG_EMPTY = 1,
    parameter bit               MSB_FIRST  = 1'b1,
    parameter logic [DIN_W-1:0] PAD_VAL    = '0,
    localparam int              DOUT_W     = DIN_W * RATIO,
    localparam int              CNT_W      = $clog2(DEPTH) + 1,
    localparam int              LANE_W     = $clog2(RATIO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_en,
    output logic              din_rdy,
    input  logic              flush,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_en,
    input  logic              dout_rd,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              prog_full,
    output logic              prog_empty,
    output logic [LANE_W-1:0] lane_cnt,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DOUT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic [DOUT_W-1:0] pack_word;
    logic              push;
    logic              pop;
    logic              din_acc;

    // Only the word that would complete a packer is blocked by full; pops never feed back here.
    assign din_rdy = !(full && (lane_cnt == LANE_W'(RATIO - 1)));
    assign din_acc = din_en && din_rdy;
    assign pop     = dout_rd && !empty;
    assign dout_en = !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    fifo_pack_lane #(
        .DIN_W     (DIN_W),
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST),
        .PAD_VAL   (PAD_VAL),
        .DOUT_W    (DOUT_W),
        .LANE_W    (LANE_W)
    ) u_pack (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_acc  (din_acc),
        .flush    (flush),
        .full     (full),
        .word     (pack_word),
        .push     (push),
        .lane_cnt (lane_cnt)
    );

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + CNT_W'(1);
            count      <= count_nxt;
            full       <= (count_nxt == CNT_W'(DEPTH));
            empty      <= (count_nxt == '0);
            prog_full  <= (count_nxt >= CNT_W'(PROG_FULL));
            prog_empty <= (count_nxt <= CNT_W'(PROG_EMPTY));
            overflow   <= overflow  || (din_en && !din_rdy);
            underflow  <= underflow || (dout_rd && empty);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= pack_word;
    end

endmodule

// File: tb/tb_fifo_s2b_sync.sv
// Directed self-checking bench for fifo_s2b_sync (4->16 bit, depth 8), with an LSB-first twin for lane order.
module tb_fifo_s2b_sync;

    logic        clk = 1'b0;
    logic        rst, din_en, flush, dout_rd;
    logic [3:0]  din;

    logic        din_rdy, dout_en, full, empty, prog_full, prog_empty, overflow, underflow;
    logic [15:0] dout;
    logic [3:0]  count;
    logic [1:0]  lane_cnt;

    logic        l_din_rdy, l_dout_en, l_full, l_empty, l_prog_full, l_prog_empty, l_overflow, l_underflow;
    logic [15:0] l_dout;
    logic [3:0]  l_count;
    logic [1:0]  l_lane_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] sb[$];
    logic [15:0] acc;
    int          nacc;
    logic [3:0]  d;
    logic [15:0] exp_w;

    always #5 clk = ~clk;

    fifo_s2b_sync u_dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .din_rdy(din_rdy), .flush(flush),
        .dout(dout), .dout_en(dout_en), .dout_rd(dout_rd), .count(count), .full(full),
        .empty(empty), .prog_full(prog_full), .prog_empty(prog_empty), .lane_cnt(lane_cnt),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_s2b_sync #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .din_rdy(l_din_rdy), .flush(flush),
        .dout(l_dout), .dout_en(l_dout_en), .dout_rd(dout_rd), .count(l_count), .full(l_full),
        .empty(l_empty), .prog_full(l_prog_full), .prog_empty(l_prog_empty), .lane_cnt(l_lane_cnt),
        .overflow(l_overflow), .underflow(l_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [3:0] w);
        acc = {acc[11:0], w};
        nacc++;
        if (nacc == 4) begin
            sb.push_back(acc);
            nacc = 0;
        end
    endtask

    task automatic put(input logic [3:0] w);
        din    = w;
        din_en = 1'b1;
        step();
        din_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(dout_en), 32'd0);
        end else begin
            chk(tag, 32'(dout), 32'(sb.pop_front()));
        end
        dout_rd = 1'b1;
        step();
        dout_rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; din_en = 1'b0; flush = 1'b0; dout_rd = 1'b0; din = '0;
        acc = '0; nacc = 0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_prog_empty", 32'(prog_empty), 32'd1);
        chk("rst_dout_en", 32'(dout_en), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_din_rdy", 32'(din_rdy), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_prog_full", 32'(prog_full), 32'd0);
        chk("rst_lane_cnt", 32'(lane_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        // basic packing, both lane orders
        put(4'h1); put(4'h2); put(4'h3);
        model_accept(4'h1); model_accept(4'h2); model_accept(4'h3);
        chk("t1_lane3", 32'(lane_cnt), 32'd3);
        chk("t1_not_yet", 32'(dout_en), 32'd0);
        put(4'h4); model_accept(4'h4);
        chk("t1_dout_en", 32'(dout_en), 32'd1);
        chk("t1_msb_word", 32'(dout), 32'h1234);
        chk("t1_lsb_word", 32'(l_dout), 32'h4321);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_prog_empty", 32'(prog_empty), 32'd1);
        pop_chk("t1_pop");
        chk("t1_empty_after", 32'(empty), 32'd1);

        // partial flush with padding
        put(4'hA); put(4'hB); put(4'hC);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t3_flush_word", 32'(dout), 32'hABC0);
        chk("t3_flush_lsb", 32'(l_dout), 32'h0CBA);
        chk("t3_lane0", 32'(lane_cnt), 32'd0);
        chk("t3_count", 32'(count), 32'd1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t3_noop_flush", 32'(count), 32'd1);
        sb.push_back(16'hABC0);
        pop_chk("t3_pop");

        // fill to full, thresholds, overflow
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) begin
                d = 4'($urandom_range(0, 15));
                put(d); model_accept(d);
                if (g == 4 && k == 3) chk("t2_pf_at5", 32'(prog_full), 32'd0);
                if (g == 5 && k == 3) begin
                    chk("t2_pf_at6", 32'(prog_full), 32'd1);
                    chk("t2_count6", 32'(count), 32'd6);
                end
            end
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count8", 32'(count), 32'd8);
        chk("t2_rdy_lane0", 32'(din_rdy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            d = 4'($urandom_range(0, 15));
            put(d); model_accept(d);
        end
        chk("t2_rdy_low", 32'(din_rdy), 32'd0);
        chk("t2_no_overflow_yet", 32'(overflow), 32'd0);
        put(4'h5);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_count_hold", 32'(count), 32'd8);
        chk("t2_lane_hold", 32'(lane_cnt), 32'd3);

        // pop does not raise din_rdy combinationally
        dout_rd = 1'b1; #1;
        chk("t5_rdy_no_comb", 32'(din_rdy), 32'd0);
        dout_rd = 1'b0;
        pop_chk("t5_pop_full");
        chk("t5_count7", 32'(count), 32'd7);
        chk("t5_rdy_back", 32'(din_rdy), 32'd1);

        // simultaneous completing word and pop
        chk("t5_head", 32'(dout), 32'(sb[0]));
        d = 4'h9;
        din = d; din_en = 1'b1; dout_rd = 1'b1;
        step();
        din_en = 1'b0; dout_rd = 1'b0;
        void'(sb.pop_front());
        model_accept(d);
        chk("t5_count_same", 32'(count), 32'd7);
        chk("t5_lane0", 32'(lane_cnt), 32'd0);
        for (int i = 0; i < 7; i++) pop_chk("t5_drain");
        chk("t5_empty", 32'(empty), 32'd1);

        dout_rd = 1'b1; step(); dout_rd = 1'b0;
        chk("t5_underflow", 32'(underflow), 32'd1);
        chk("t5_uf_count", 32'(count), 32'd0);

        // reset mid-operation
        for (int i = 0; i < 22; i++) put(4'(i));
        chk("t6_pre_count", 32'(count), 32'd5);
        chk("t6_pre_lane", 32'(lane_cnt), 32'd2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_lane", 32'(lane_cnt), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_underflow", 32'(underflow), 32'd0);
        chk("t6_dout", 32'(dout), 32'd0);
        chk("t6_lsb_count", 32'(l_count), 32'd0);
        sb.delete();
        nacc = 0;

        // streaming against scoreboard
        for (int n = 0; n < 400; n++) begin
            if (dout_en) begin
                if (sb.size() == 0) chk("t4_extra_word", 32'(dout_en), 32'd0);
                else chk("t4_stream", 32'(dout), 32'(sb.pop_front()));
                dout_rd = 1'b1;
            end else begin
                dout_rd = 1'b0;
            end
            d = 4'($urandom_range(0, 15));
            din = d; din_en = 1'b1;
            model_accept(d);
            step();
        end
        din_en = 1'b0;
        for (int n = 0; n < 50 && sb.size() > 0; n++) begin
            if (dout_en) begin
                chk("t4_drain", 32'(dout), 32'(sb.pop_front()));
                dout_rd = 1'b1;
            end else begin
                dout_rd = 1'b0;
            end
            step();
        end
        dout_rd = 1'b0;
        chk("t4_sb_left", 32'(sb.size()), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_underflow", 32'(underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
